// File: rtl/deserializer_pkg.sv
// deserializer_pkg: shared types for the deserializer.
//   t_states - FSM states, matching the serializer FSM naming.
package deserializer_pkg;

    typedef enum logic {
        s_COLLECT = 1'b0,
        s_HOLD    = 1'b1
    } t_states;

endpackage : deserializer_pkg

// File: rtl/deserializer.sv
// deserializer: packs N_PARALLEL words of DATA_WIDTH bits, received over a
// valid/ready slave port, into one N_PARALLEL*DATA_WIDTH frame presented on a
// valid/ready master port. Word 0 lands in bits [DATA_WIDTH-1:0].
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_data, i_valid     slave word and its valid
//   o_ready             slave ready (registered)
//   o_data, o_valid     assembled frame and its valid (registered)
//   i_ready             master ready
//   i_last, o_count     only with DESERIALIZER_LAST_EN: early frame close on
//                       i_last, and number of words in the presented frame
//
// Build option: `define DESERIALIZER_LAST_EN enables the i_last / o_count
// short-frame feature; without it frames close only after N_PARALLEL words.
module deserializer
    import deserializer_pkg::*;
#(
    parameter int unsigned N_PARALLEL = 30,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic [DATA_WIDTH-1:0]              i_data,
    input  logic                               i_valid,
    output logic                               o_ready,
    output logic [N_PARALLEL*DATA_WIDTH-1:0]   o_data,
    output logic                               o_valid,
`ifdef DESERIALIZER_LAST_EN
    input  logic                               i_last,
    output logic [$clog2(N_PARALLEL+1)-1:0]    o_count,
`endif
    input  logic                               i_ready
);

    localparam int unsigned CNT_W   = $clog2(N_PARALLEL);
    localparam int unsigned COUNT_W = $clog2(N_PARALLEL + 1);
    localparam int unsigned FRAME_W = N_PARALLEL * DATA_WIDTH;

    t_states              state_q, state_d;
    logic [CNT_W-1:0]     cntr_q, cntr_d;
    logic [FRAME_W-1:0]   buf_q, buf_d;
    logic [FRAME_W-1:0]   data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ready_q, ready_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 last_c;
    logic                 close_c;

`ifdef DESERIALIZER_LAST_EN
    assign last_c = i_last;
`else
    assign last_c = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= s_COLLECT;
            cntr_q  <= '0;
            buf_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cntr_q  <= cntr_d;
            buf_q   <= buf_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            count_q <= count_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cntr_d  = cntr_q;
        buf_d   = buf_q;
        data_d  = data_q;
        valid_d = valid_q;
        ready_d = ready_q;
        count_d = count_q;
        close_c = 1'b0;

        case (state_q)
            s_COLLECT: begin
                if (i_valid && ready_q) begin
                    for (int i = 0; i < int'(N_PARALLEL); i++) begin
                        if (cntr_q == CNT_W'(i)) begin
                            buf_d[i*DATA_WIDTH +: DATA_WIDTH] = i_data;
                        end
                    end
                    close_c = (cntr_q == CNT_W'(N_PARALLEL - 1)) || last_c;
                    if (close_c) begin
                        // Frame includes the word written this cycle
                        data_d  = buf_d;
                        valid_d = 1'b1;
                        ready_d = 1'b0;
                        count_d = COUNT_W'(cntr_q) + COUNT_W'(1);
                        cntr_d  = '0;
                        state_d = s_HOLD;
                    end else begin
                        cntr_d = cntr_q + CNT_W'(1);
                    end
                end
            end
            s_HOLD: begin
                if (valid_q && i_ready) begin
                    // Clearing here is what makes short-frame slots read 0
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    buf_d   = '0;
                    state_d = s_COLLECT;
                end
            end
            default: begin
                state_d = s_COLLECT;
            end
        endcase
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_data  = data_q;

`ifdef DESERIALIZER_LAST_EN
    assign o_count = count_q;
`else
    logic unused_count;
    assign unused_count = ^count_q;
`endif

endmodule : deserializer

// File: tb/tb_deserializer.sv
module tb_deserializer;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;

    logic          i_clk;
    logic          i_reset;
    logic [DW-1:0] i_data;
    logic          i_valid;
    logic          o_ready;
    logic [N*DW-1:0] o_data;
    logic          o_valid;
    logic          i_ready;
    logic          i_last;
`ifdef DESERIALIZER_LAST_EN
    logic [2:0]    o_count;
`endif

    int n_cmp;
    int n_err;
    int cyc;

    deserializer #(.N_PARALLEL(N), .DATA_WIDTH(DW)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
`ifdef DESERIALIZER_LAST_EN
        .i_last  (i_last),
        .o_count (o_count),
`endif
        .i_ready (i_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Present one word from a negedge and return at the negedge after it is accepted.
    task automatic drive_word(input logic [DW-1:0] d, input logic last, output bit timed_out);
        timed_out = 1'b1;
        i_valid   = 1'b1;
        i_data    = d;
        i_last    = last;
        for (int k = 0; k < 50; k++) begin
            if (o_ready) begin
                @(negedge i_clk);
                timed_out = 1'b0;
                break;
            end
            @(negedge i_clk);
        end
        i_last = 1'b0;
    endtask

    // Four words back to back, word 0 from the low byte of w.
    task automatic drive_frame(input logic [31:0] w, output bit timed_out);
        bit to;
        timed_out = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_word(w[k*8 +: 8], 1'b0, to);
            timed_out = timed_out | to;
        end
    endtask

    task automatic idle();
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (3) @(negedge i_clk);
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (2) @(negedge i_clk);
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        n_cmp++; if (o_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 00000000", o_data); end
        i_reset = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_continuous();
        bit to, to2;
        i_ready = 1'b1;
        drive_frame(32'h44332211, to);
        n_cmp++; if (to) begin n_err++; $display("FAIL cont_timeout: frame not accepted"); end
        n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL cont_valid: got %b want 1", o_valid); end
        n_cmp++; if (o_data !== 32'h44332211) begin n_err++; $display("FAIL cont_data: got %h want 44332211", o_data); end
        n_cmp++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL cont_ready_low: got %b want 0", o_ready); end
        i_valid = 1'b1;
        i_data  = 8'h55;
        @(negedge i_clk);
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL cont_valid_one_cycle: got %b want 0", o_valid); end
        n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL cont_ready_back: got %b want 1", o_ready); end
        drive_word(8'h55, 1'b0, to2); to = to2;
        drive_word(8'h66, 1'b0, to2); to = to | to2;
        drive_word(8'h77, 1'b0, to2); to = to | to2;
        drive_word(8'h88, 1'b0, to2); to = to | to2;
        n_cmp++; if (to) begin n_err++; $display("FAIL cont2_timeout: frame not accepted"); end
        n_cmp++; if (o_data !== 32'h88776655) begin n_err++; $display("FAIL cont2_data: got %h want 88776655", o_data); end
        idle();
    endtask

    task automatic test_hold();
        bit to;
        logic [31:0] held;
        i_ready = 1'b0;
        drive_frame(32'hA4A3A2A1, to);
        held = 32'hA4A3A2A1;
        n_cmp++; if (to) begin n_err++; $display("FAIL hold_timeout: frame not accepted"); end
        i_valid = 1'b1;
        i_data  = 8'hEE;
        for (int k = 0; k < 5; k++) begin
            @(negedge i_clk);
            n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid[%0d]: got %b want 1", k, o_valid); end
            n_cmp++; if (o_data !== held) begin n_err++; $display("FAIL hold_data[%0d]: got %h want %h", k, o_data, held); end
            n_cmp++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL hold_ready[%0d]: got %b want 0", k, o_ready); end
        end
        i_ready = 1'b1;
        i_valid = 1'b0;
        @(negedge i_clk);
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL hold_release_valid: got %b want 0", o_valid); end
        n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL hold_release_ready: got %b want 1", o_ready); end
        drive_frame(32'h04030201, to);
        n_cmp++; if (o_data !== 32'h04030201) begin n_err++; $display("FAIL hold_no_extra: got %h want 04030201", o_data); end
        idle();
    endtask

    task automatic test_toggle();
        logic       vv [7];
        logic [7:0] dd [7];
        vv = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        dd = '{8'h10, 8'h99, 8'h20, 8'h98, 8'h30, 8'h97, 8'h40};
        i_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            i_valid = vv[k];
            i_data  = dd[k];
            @(negedge i_clk);
            if (k == 5) begin
                n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL toggle_early_valid: got %b want 0", o_valid); end
            end
        end
        n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL toggle_valid: got %b want 1", o_valid); end
        n_cmp++; if (o_data !== 32'h40302010) begin n_err++; $display("FAIL toggle_data: got %h want 40302010", o_data); end
        idle();
    endtask

    task automatic test_reset_mid();
        bit to, to2;
        drive_word(8'hC1, 1'b0, to);
        drive_word(8'hC2, 1'b0, to2);
        i_valid = 1'b0;
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", o_valid); end
        n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %b want 1", o_ready); end
        n_cmp++; if (o_data !== 32'h0) begin n_err++; $display("FAIL rstmid_data: got %h want 00000000", o_data); end
        drive_frame(32'hD4D3D2D1, to);
        n_cmp++; if (o_data !== 32'hD4D3D2D1) begin n_err++; $display("FAIL rstmid_frame: got %h want D4D3D2D1", o_data); end
        idle();
        // Reset while a frame is being held
        i_ready = 1'b0;
        drive_frame(32'hE4E3E2E1, to);
        i_valid = 1'b0;
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rsthold_valid: got %b want 0", o_valid); end
        n_cmp++; if (o_data !== 32'h0) begin n_err++; $display("FAIL rsthold_data: got %h want 00000000", o_data); end
        n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL rsthold_ready: got %b want 1", o_ready); end
        idle();
    endtask

    task automatic test_back_to_back();
        bit to;
        int t0;
        int t1;
        i_ready = 1'b1;
        drive_frame(32'h04030201, to);
        t0 = cyc;
        n_cmp++; if (o_data !== 32'h04030201) begin n_err++; $display("FAIL b2b_first: got %h want 04030201", o_data); end
        drive_frame(32'h08070605, to);
        t1 = cyc;
        n_cmp++; if (o_data !== 32'h08070605) begin n_err++; $display("FAIL b2b_second: got %h want 08070605", o_data); end
        n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %b want 1", o_valid); end
        n_cmp++; if ((t1 - t0) != 5) begin n_err++; $display("FAIL b2b_period: got %0d cycles want 5", t1 - t0); end
        idle();
    endtask

`ifdef DESERIALIZER_LAST_EN
    task automatic test_last();
        bit to, to2;
        i_ready = 1'b1;
        drive_word(8'hAA, 1'b0, to);
        drive_word(8'hBB, 1'b1, to2);
        n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL last_valid: got %b want 1", o_valid); end
        n_cmp++; if (o_data !== 32'h0000BBAA) begin n_err++; $display("FAIL last_data: got %h want 0000BBAA", o_data); end
        n_cmp++; if (o_count !== 3'd2) begin n_err++; $display("FAIL last_count: got %0d want 2", o_count); end
        idle();
        drive_word(8'h55, 1'b1, to);
        n_cmp++; if (o_data !== 32'h00000055) begin n_err++; $display("FAIL last_single: got %h want 00000055", o_data); end
        n_cmp++; if (o_count !== 3'd1) begin n_err++; $display("FAIL last_single_count: got %0d want 1", o_count); end
        idle();
        drive_word(8'h01, 1'b0, to);
        drive_word(8'h02, 1'b0, to);
        drive_word(8'h03, 1'b0, to);
        drive_word(8'h04, 1'b1, to);
        n_cmp++; if (o_data !== 32'h04030201) begin n_err++; $display("FAIL last_full: got %h want 04030201", o_data); end
        n_cmp++; if (o_count !== 3'd4) begin n_err++; $display("FAIL last_full_count: got %0d want 4", o_count); end
        idle();
    endtask
`endif

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        cyc     = 0;
        i_reset = 1'b1;
        i_data  = '0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_last  = 1'b0;
        test_reset();
        test_continuous();
        test_hold();
        test_toggle();
        test_reset_mid();
        test_back_to_back();
`ifdef DESERIALIZER_LAST_EN
        test_last();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_deserializer
